// File: rtl/robo_map_engine_if.sv
// robo_map_engine_if: command, map-load and sensor signals of the grid-world robot engine
interface robo_map_engine_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 5
);
    logic             avancar;
    logic             girar;
    logic             remover;
    logic             map_we;
    logic [ROW_W-1:0] map_row;
    logic [COL_W-1:0] map_col;
    logic [1:0]       map_data;
    logic             head_out;
    logic             left_out;
    logic             under_out;
    logic             barrier_out;
    logic             busy;
    logic             cmd_err;
    logic [ROW_W-1:0] robo_row;
    logic [COL_W-1:0] robo_col;
    logic [1:0]       robo_orientacao;
    logic [15:0]      move_count;

    modport master (
        output avancar, girar, remover, map_we, map_row, map_col, map_data,
        input  head_out, left_out, under_out, barrier_out, busy, cmd_err,
               robo_row, robo_col, robo_orientacao, move_count
    );
    modport slave (
        input  avancar, girar, remover, map_we, map_row, map_col, map_data,
        output head_out, left_out, under_out, barrier_out, busy, cmd_err,
               robo_row, robo_col, robo_orientacao, move_count
    );
endinterface

// File: rtl/robo_map_engine.sv
// robo_map_engine: grid-world robot with loadable map, one-hot commands and multi-cycle rubble removal
module robo_map_engine #(
    parameter int ROWS        = 10,
    parameter int COLS        = 20,
    parameter int ROW_W       = 4,
    parameter int COL_W       = 5,
    parameter int START_ROW   = 0,
    parameter int START_COL   = 0,
    parameter int START_DIR   = 1,
    parameter int RUBBLE_HITS = 3
) (
    input logic clock,
    input logic reset,
    robo_map_engine_if.slave bus
);
    localparam int CNT_W = RUBBLE_HITS > 1 ? $clog2(RUBBLE_HITS) : 1;
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(RUBBLE_HITS - 1);
    localparam logic [ROW_W:0] ROWS_X = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0] COLS_X = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0] R1 = 1;
    localparam logic [COL_W:0] C1 = 1;

    typedef enum logic {IDLE, REMOVE} state_t;

    state_t           state, state_n;
    logic [1:0]       map_q [ROWS][COLS];
    logic [ROW_W-1:0] row_q, tgt_r;
    logic [COL_W-1:0] col_q, tgt_c;
    logic [1:0]       dir_q, left_dir;
    logic [15:0]      cnt_q;
    logic [CNT_W-1:0] hit_q;
    logic             err_q;
    logic [ROW_W:0]   ah_r, lf_r;
    logic [COL_W:0]   ah_c, lf_c;
    logic             ah_in, lf_in, wr_in;
    logic [1:0]       ah_cell, lf_cell;
    logic             idle, multi, any_cmd, do_move, do_turn, do_rem, last, err_n;

    // Neighbour indices carry an extra bit so stepping off either edge lands out of range
    function automatic logic [ROW_W:0] step_r(input logic [ROW_W-1:0] r, input logic [1:0] d);
        return d == 2'd0 ? {1'b0, r} - R1 : d == 2'd2 ? {1'b0, r} + R1 : {1'b0, r};
    endfunction

    function automatic logic [COL_W:0] step_c(input logic [COL_W-1:0] c, input logic [1:0] d);
        return d == 2'd3 ? {1'b0, c} - C1 : d == 2'd1 ? {1'b0, c} + C1 : {1'b0, c};
    endfunction

    assign left_dir = dir_q + 2'd3;
    assign ah_r     = step_r(row_q, dir_q);
    assign ah_c     = step_c(col_q, dir_q);
    assign lf_r     = step_r(row_q, left_dir);
    assign lf_c     = step_c(col_q, left_dir);
    assign ah_in    = ah_r < ROWS_X && ah_c < COLS_X;
    assign lf_in    = lf_r < ROWS_X && lf_c < COLS_X;
    assign wr_in    = {1'b0, bus.map_row} < ROWS_X && {1'b0, bus.map_col} < COLS_X;
    assign ah_cell  = ah_in ? map_q[ah_r[ROW_W-1:0]][ah_c[COL_W-1:0]] : 2'd0;
    assign lf_cell  = lf_in ? map_q[lf_r[ROW_W-1:0]][lf_c[COL_W-1:0]] : 2'd0;

    assign bus.head_out        = !ah_in || ah_cell == 2'd1 || ah_cell == 2'd2;
    assign bus.left_out        = !lf_in || lf_cell == 2'd1 || lf_cell == 2'd2;
    assign bus.barrier_out     = ah_in && ah_cell == 2'd2;
    assign bus.under_out       = map_q[row_q][col_q] == 2'd3;
    assign bus.busy            = state == REMOVE;
    assign bus.cmd_err         = err_q;
    assign bus.robo_row        = row_q;
    assign bus.robo_col        = col_q;
    assign bus.robo_orientacao = dir_q;
    assign bus.move_count      = cnt_q;

    always_ff @(posedge clock)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        idle    = state == IDLE;
        any_cmd = bus.avancar | bus.girar | bus.remover;
        multi   = (bus.avancar & bus.girar) | (bus.avancar & bus.remover) | (bus.girar & bus.remover);
        do_move = idle && !multi && bus.avancar && !bus.head_out;
        do_turn = idle && !multi && bus.girar;
        do_rem  = idle && !multi && bus.remover && bus.barrier_out;
        last    = !idle && hit_q == HIT_LAST;
        err_n   = !idle ? any_cmd
                : multi | (bus.avancar & bus.head_out) | (bus.remover & !bus.barrier_out);
        state_n = idle ? (do_rem ? REMOVE : IDLE) : (last ? IDLE : REMOVE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= ROW_W'(START_ROW);
            col_q <= COL_W'(START_COL);
            dir_q <= 2'(START_DIR);
            cnt_q <= '0;
            hit_q <= '0;
            err_q <= 1'b0;
            tgt_r <= '0;
            tgt_c <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    map_q[r][c] <= 2'd0;
        end else begin
            err_q <= err_n;
            if (do_turn) dir_q <= dir_q + 2'd1;
            if (do_move) begin
                row_q <= ah_r[ROW_W-1:0];
                col_q <= ah_c[COL_W-1:0];
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
            if (do_rem) begin
                tgt_r <= ah_r[ROW_W-1:0];
                tgt_c <= ah_c[COL_W-1:0];
                hit_q <= '0;
            end else if (!idle) begin
                hit_q <= hit_q + CNT_W'(1);
            end
            // External load is ordered last so it wins over the clear on a shared edge
            if (last) map_q[tgt_r][tgt_c] <= 2'd0;
            if (bus.map_we && wr_in) map_q[bus.map_row][bus.map_col] <= bus.map_data;
        end
    end
endmodule

// File: tb/tb_robo_map_engine.sv
// tb_robo_map_engine: table-driven directed checks of robo_map_engine plus edge and reset sequences
module tb_robo_map_engine;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    robo_map_engine_if #(.ROW_W(4), .COL_W(5)) bus ();
    robo_map_engine dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic rst, a, g, r, we;
        int   mr, mc, md;
        int   row, col, dir;
        logic head, left, under, bar, busy, err;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, a, g, r, we, input int mr, mc, md);
        reset        = rs;
        bus.avancar  = a;
        bus.girar    = g;
        bus.remover  = r;
        bus.map_we   = we;
        bus.map_row  = 4'(mr);
        bus.map_col  = 5'(mc);
        bus.map_data = 2'(md);
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input int row, col, dir,
                             input logic head, left, under, bar, busy, err, input int cnt);
        chk({tag, ".row"}, int'(bus.robo_row), row);
        chk({tag, ".col"}, int'(bus.robo_col), col);
        chk({tag, ".dir"}, int'(bus.robo_orientacao), dir);
        chk({tag, ".head"}, int'(bus.head_out), int'(head));
        chk({tag, ".left"}, int'(bus.left_out), int'(left));
        chk({tag, ".under"}, int'(bus.under_out), int'(under));
        chk({tag, ".barrier"}, int'(bus.barrier_out), int'(bar));
        chk({tag, ".busy"}, int'(bus.busy), int'(busy));
        chk({tag, ".cmd_err"}, int'(bus.cmd_err), int'(err));
        chk({tag, ".move_count"}, int'(bus.move_count), cnt);
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // rst a g r we mr mc md | row col dir head left under bar busy err cnt
        tbl.push_back('{0,0,0,0,1, 0,3,1,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,  0,1,1, 0,1,0,0,0,0, 1});
        tbl.push_back('{0,1,0,0,0, 0,0,0,  0,2,1, 1,1,0,0,0,0, 2});
        tbl.push_back('{0,1,0,0,0, 0,0,0,  0,2,1, 1,1,0,0,0,1, 2});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,2,1, 1,1,0,0,0,0, 2});
        tbl.push_back('{1,0,0,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,  0,0,2, 0,0,0,0,0,0, 0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,  0,0,3, 1,0,0,0,0,0, 0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,  0,0,0, 1,1,0,0,0,0, 0});
        tbl.push_back('{0,0,1,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,0,0,0,1, 0,1,2,  0,0,1, 1,1,0,1,0,0, 0});
        tbl.push_back('{0,0,0,1,0, 0,0,0,  0,0,1, 1,1,0,1,1,0, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 1,1,0,1,1,0, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 1,1,0,1,1,0, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,0,0,0,1, 0,1,2,  0,0,1, 1,1,0,1,0,0, 0});
        tbl.push_back('{0,0,0,1,0, 0,0,0,  0,0,1, 1,1,0,1,1,0, 0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,  0,0,1, 1,1,0,1,1,1, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 1,1,0,1,1,0, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,1,1,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,1, 0});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,0,0,0,1, 0,1,3,  0,0,1, 0,1,0,0,0,0, 0});
        tbl.push_back('{0,1,0,0,0, 0,0,0,  0,1,1, 0,1,1,0,0,0, 1});
        tbl.push_back('{0,0,0,0,1, 12,2,1, 0,1,1, 0,1,1,0,0,0, 1});
        tbl.push_back('{0,0,0,1,0, 0,0,0,  0,1,1, 0,1,1,0,0,1, 1});
        tbl.push_back('{0,0,1,0,0, 0,0,0,  0,1,2, 0,0,1,0,0,0, 1});
        tbl.push_back('{0,0,0,0,1, 1,1,2,  0,1,2, 1,0,1,1,0,0, 1});
        tbl.push_back('{0,0,0,1,0, 0,0,0,  0,1,2, 1,0,1,1,1,0, 1});
        tbl.push_back('{0,0,0,0,1, 1,1,1,  0,1,2, 1,0,1,0,1,0, 1});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,1,2, 1,0,1,0,1,0, 1});
        tbl.push_back('{0,0,0,0,0, 0,0,0,  0,1,2, 0,0,1,0,0,0, 1});

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check_all("reset", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].a, tbl[i].g, tbl[i].r, tbl[i].we, tbl[i].mr, tbl[i].mc, tbl[i].md);
            check_all($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, tbl[i].dir, tbl[i].head,
                      tbl[i].left, tbl[i].under, tbl[i].bar, tbl[i].busy, tbl[i].err, tbl[i].cnt);
        end

        // east edge: col 19 heading E must read off-map, not wrap
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 19; k++) drive(0, 1, 0, 0, 0, 0, 0, 0);
        check_all("east_edge", 0, 19, 1, 1, 1, 0, 0, 0, 0, 19);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        check_all("east_block", 0, 19, 1, 1, 1, 0, 0, 0, 1, 19);

        // reset in the second busy cycle of a removal
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 2, 2);
        drive(0, 0, 1, 0, 1, 3, 7, 3);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        check_all("pre_remove", 0, 1, 1, 1, 1, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        check_all("remove_c1", 0, 1, 1, 1, 1, 0, 1, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check_all("mid_reset", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        begin
            int nz = 0;
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 20; c++)
                    if (dut.map_q[r][c] != 2'd0) nz++;
            chk("mid_reset.nonzero_cells", nz, 0);
        end
        idle_cycle();
        check_all("post_reset_idle", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/robo_map_engine.md
Name: robo_map_engine

Overview:
- Parametrised grid-world robot engine: holds a ROWS x COLS cell map, robot position and heading.
- Executes one-hot commands: avancar (advance), girar (turn), remover (clear rubble).
- Drives sensor outputs used by the agent controller: head, left, under, barrier.
- Adds over the fixed 10x20 version: runtime map load port, multi-cycle rubble removal FSM with busy, command error flag, move counter.

Parameters:
- ROWS, 10, map rows.
- COLS, 20, map columns.
- ROW_W, 4, row index width; must satisfy 2^ROW_W >= ROWS.
- COL_W, 5, column index width; must satisfy 2^COL_W >= COLS.
- START_ROW, 0, row after reset.
- START_COL, 0, column after reset.
- START_DIR, 1, heading after reset.
- RUBBLE_HITS, 3, cycles needed to clear one rubble cell; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- avancar  in  1  advance one cell.
- girar  in  1  rotate clockwise 90 degrees.
- remover  in  1  start removal of rubble ahead.
- map_we  in  1  map write enable.
- map_row  in  ROW_W  write row.
- map_col  in  COL_W  write column.
- map_data  in  2  cell code: 0 free, 1 wall, 2 rubble, 3 exit.
- head_out  out  1  cell ahead blocked (wall, rubble or off-map).
- left_out  out  1  cell to the left blocked (same rule).
- under_out  out  1  current cell is exit.
- barrier_out  out  1  cell ahead is rubble.
- busy  out  1  removal in progress.
- cmd_err  out  1  one-cycle pulse on a rejected command.
- robo_row  out  ROW_W  current row.
- robo_col  out  COL_W  current column.
- robo_orientacao  out  2  heading: 0 N (row-1), 1 E (col+1), 2 S (row+1), 3 W (col-1).
- move_count  out  16  successful advances, saturating at 0xFFFF.

Behaviour:
- Reset (synchronous): all cells become 0; row/col/heading load START_*; FSM to IDLE; busy=0, cmd_err=0, move_count=0.
- Reset mid-removal: removal is aborted, map cleared, no cell modified beyond the clear.
- Sensors are combinational from registered state: they are valid in the same cycle as any position, heading or map change.
- Left direction = (heading+3) mod 4.
- Off-map neighbours count as blocked; barrier_out=0 for off-map.
- Index arithmetic uses one extra bit so row 0 heading N and col COLS-1 heading E never wrap.
- Command decode is in IDLE only.
- More than one of avancar/girar/remover high in one cycle: none executes; cmd_err=1 next cycle.
- Any command while busy=1: ignored; cmd_err=1.
- girar: heading <= heading+1 mod 4 at the clock edge (3 wraps to 0).
- avancar with head_out=0: position updates at the edge; move_count+1, saturating.
- avancar with head_out=1: no move; cmd_err=1.
- remover with barrier_out=1: target cell coordinates are latched; go REMOVE; busy=1 from the next cycle.
- remover with barrier_out=0: cmd_err=1, no state change.
- REMOVE: counter counts RUBBLE_HITS cycles.
  - On the last cycle the latched cell is written 0, FSM returns to IDLE, busy=0 in the following cycle.
  - With RUBBLE_HITS=3, busy is high exactly 3 cycles.
- Map write (map_we=1):
  - Takes effect at the edge in any state.
  - Out-of-range row/col: ignored silently.
  - A write to the latched removal cell during REMOVE wins on that edge; the removal completion still writes 0 at the end.
- cmd_err is registered, high for exactly one cycle per rejected command.
- Outputs hold their values when no command is present.

Test Plan:
- Reset, load wall at (0,3), heading E at (0,0); avancar x2 -> col=2, move_count=2, head_out=1; third avancar -> col stays 2, cmd_err pulse.
- At (0,0): girar x4 -> orientacao 2,3,0,1 in successive cycles; at heading 0, head_out=1 (off-map) and left_out=1 (col -1).
- Rubble at (0,1), heading E at (0,0): remover -> barrier_out=1 before; busy high 3 cycles; then cell (0,1)=0, barrier_out=0, head_out=0.
- During busy, pulse avancar -> cmd_err=1, position unchanged; avancar+girar together in IDLE -> cmd_err=1, no change.
- Write exit (3) at (0,1), avancar -> under_out=1 in the same cycle as col=1; write to row 12 -> map unchanged.
- Reset asserted in cycle 2 of removal -> busy=0, position (START_ROW,START_COL), orientacao=START_DIR, all cells 0, move_count=0.
